uart_boot_loader: RTL

//  Upstream stage of the CPU core: receives a program image over UART (8N1), packs

---
 rtl/uart_boot_loader.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/uart_boot_loader.sv
// UART (8N1) program-image loader: packs bytes into 32-bit words, writes them to RAM,
// then releases the core. Optional trailing XOR checksum is enabled by UART_BOOT_CHECKSUM_EN.
module uart_boot_loader #(
    parameter int CLKS_PER_BIT = 434,
    parameter int ADDR_W       = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_data,
    output logic              mem_we,
    output logic              core_rst_n,
    output logic              busy,
    output logic              err
);
    localparam int              CNT_W     = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [7:0]      SYNC_BYTE = 8'hA5;

    typedef enum logic [1:0] {R_IDLE = 2'd0, R_START = 2'd1, R_DATA = 2'd2, R_STOP = 2'd3} rx_state_t;

    typedef enum logic [2:0] {
        P_SYNC = 3'd0, P_LEN0 = 3'd1, P_LEN1 = 3'd2, P_DATA = 3'd3, P_DONE = 3'd4
`ifdef UART_BOOT_CHECKSUM_EN
        , P_CHK = 3'd5
`endif
    } p_state_t;

    logic             rx_meta_r, rx_sync_r;
    rx_state_t        rx_state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [2:0]       bit_idx_r;
    logic [7:0]       shift_r;
    logic             byte_valid_r, frame_err_r;

    p_state_t         p_state_r;
    logic [15:0]      words_left_r;
    logic [1:0]       byte_idx_r;
    logic [31:0]      word_r;
    logic             last_pend_r;

    // Two-flop synchroniser for the asynchronous serial line (idles high)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
        end else begin
            rx_meta_r <= rx;
            rx_sync_r <= rx_meta_r;
        end
    end

    // UART receiver: mid-bit sampling, one-cycle byte_valid / frame_err pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state_r   <= R_IDLE;
            cnt_r        <= '0;
            bit_idx_r    <= 3'd0;
            shift_r      <= 8'd0;
            byte_valid_r <= 1'b0;
            frame_err_r  <= 1'b0;
        end else begin
            byte_valid_r <= 1'b0;
            frame_err_r  <= 1'b0;
            case (rx_state_r)
                R_IDLE: begin
                    cnt_r     <= '0;
                    bit_idx_r <= 3'd0;
                    if (!rx_sync_r) rx_state_r <= R_START;
                end
                R_START: begin
                    if (cnt_r == HALF_M1) begin
                        cnt_r      <= '0;
                        rx_state_r <= rx_sync_r ? R_IDLE : R_DATA;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                R_DATA: begin
                    if (cnt_r == FULL_M1) begin
                        cnt_r     <= '0;
                        shift_r   <= {rx_sync_r, shift_r[7:1]};
                        bit_idx_r <= bit_idx_r + 3'd1;
                        if (bit_idx_r == 3'd7) rx_state_r <= R_STOP;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                R_STOP: begin
                    if (cnt_r == FULL_M1) begin
                        cnt_r        <= '0;
                        byte_valid_r <= rx_sync_r;
                        frame_err_r  <= ~rx_sync_r;
                        rx_state_r   <= R_IDLE;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                default: rx_state_r <= R_IDLE;
            endcase
        end
    end

`ifdef UART_BOOT_CHECKSUM_EN
    logic [7:0] chk_r;

    // Running XOR over the length and payload bytes of the current load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chk_r <= 8'd0;
        end else if (byte_valid_r) begin
            if ((p_state_r == P_SYNC || p_state_r == P_DONE) && shift_r == SYNC_BYTE) begin
                chk_r <= 8'd0;
            end else if (p_state_r == P_LEN0 || p_state_r == P_LEN1 || p_state_r == P_DATA) begin
                chk_r <= chk_r ^ shift_r;
            end
        end
    end
`endif

    // Protocol engine: sync, length, word packing, memory strobes and core release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_state_r    <= P_SYNC;
            words_left_r <= 16'd0;
            byte_idx_r   <= 2'd0;
            word_r       <= 32'd0;
            last_pend_r  <= 1'b0;
            mem_addr     <= '0;
            mem_data     <= 32'd0;
            mem_we       <= 1'b0;
            core_rst_n   <= 1'b0;
            busy         <= 1'b0;
            err          <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            if (mem_we) mem_addr <= mem_addr + ADDR_W'(1);
            // Release the core only once the final strobe has been retired
            if (mem_we && last_pend_r) begin
                last_pend_r <= 1'b0;
                p_state_r   <= P_DONE;
                core_rst_n  <= 1'b1;
                busy        <= 1'b0;
            end
            if (frame_err_r) begin
                if (p_state_r != P_SYNC && p_state_r != P_DONE) begin
                    p_state_r   <= P_SYNC;
                    err         <= 1'b1;
                    busy        <= 1'b0;
                    core_rst_n  <= 1'b0;
                    last_pend_r <= 1'b0;
                end
            end else if (byte_valid_r) begin
                case (p_state_r)
                    P_SYNC, P_DONE: begin
                        if (shift_r == SYNC_BYTE) begin
                            p_state_r  <= P_LEN0;
                            busy       <= 1'b1;
                            err        <= 1'b0;
                            core_rst_n <= 1'b0;
                            mem_addr   <= '0;
                        end
                    end
                    P_LEN0: begin
                        words_left_r[7:0] <= shift_r;
                        p_state_r         <= P_LEN1;
                    end
                    P_LEN1: begin
                        words_left_r[15:8] <= shift_r;
                        byte_idx_r         <= 2'd0;
                        if ({shift_r, words_left_r[7:0]} == 16'd0) begin
`ifdef UART_BOOT_CHECKSUM_EN
                            p_state_r <= P_CHK;
`else
                            p_state_r  <= P_DONE;
                            core_rst_n <= 1'b1;
                            busy       <= 1'b0;
`endif
                        end else begin
                            p_state_r <= P_DATA;
                        end
                    end
                    P_DATA: begin
                        word_r     <= {shift_r, word_r[31:8]};
                        byte_idx_r <= byte_idx_r + 2'd1;
                        if (byte_idx_r == 2'd3) begin
                            mem_we       <= 1'b1;
                            mem_data     <= {shift_r, word_r[31:8]};
                            words_left_r <= words_left_r - 16'd1;
                            if (words_left_r == 16'd1) begin
`ifdef UART_BOOT_CHECKSUM_EN
                                p_state_r <= P_CHK;
`else
                                last_pend_r <= 1'b1;
`endif
                            end
                        end
                    end
`ifdef UART_BOOT_CHECKSUM_EN
                    P_CHK: begin
                        if (shift_r == chk_r) begin
                            p_state_r  <= P_DONE;
                            core_rst_n <= 1'b1;
                            busy       <= 1'b0;
                        end else begin
                            p_state_r <= P_SYNC;
                            err       <= 1'b1;
                            busy      <= 1'b0;
                        end
                    end
`endif
                    default: p_state_r <= P_SYNC;
                endcase
            end
        end
    end
endmodule
